result_pipeline: RTL and testbench

// Producer side of operand forwarding: carries destination-register metadata and results of in-flight

---
 rtl/result_pipeline_pkg.sv | 38 +++
 rtl/result_pipeline_if.sv | 57 +++++
 rtl/result_pipeline_stage_reg.sv | 67 ++++++
 rtl/result_pipeline.sv | 115 +++++++++++
 tb/tb_result_pipeline.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// result_pipeline_pkg
// Shared widths and stage-metadata types for the result pipeline.
//   DATA_W       : result / register width
//   ADDR_W       : register address width (8 registers)
//   CNT_W        : width of the retired-instruction counter
//   NUM_STAGES   : p3 (EX), p4 (MEM), p5 (WB)
//   stage_meta_t : per-stage destination metadata
//   STAGE_BUBBLE : metadata of an empty slot (nothing valid, writes r0)
// -----------------------------------------------------------------------------
package result_pipeline_pkg;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 3;
   localparam int CNT_W      = 16;
   localparam int NUM_STAGES = 3;

   // Stage indices inside the stage arrays of the top level.
   localparam int S_P3 = 0;
   localparam int S_P4 = 1;
   localparam int S_P5 = 2;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic              is_load;
      logic [ADDR_W-1:0] dst;
   } stage_meta_t;

   localparam stage_meta_t STAGE_BUBBLE = stage_meta_t'('0);

   // A stage can hand its result to consumers only if it holds a real
   // instruction that actually writes a register.
   function automatic logic meta_writes(input stage_meta_t m);
      return m.valid & m.we;
   endfunction

endpackage

// File: rtl/result_pipeline_if.sv
// -----------------------------------------------------------------------------
// result_pipeline_if
// Bundles every non-clock/reset signal of the result pipeline.
//   master : the pipeline itself (consumes control/decode/datapath inputs,
//            drives forwarding taps, hazard flag, register-file port, counter)
//   slave  : the surrounding core (decode latch, ALU, data memory, regfile)
// -----------------------------------------------------------------------------
interface result_pipeline_if;
   import result_pipeline_pkg::*;

   // Inputs to the pipeline
   logic              hold;
   logic              flush_p3;
   logic              valid_p2;
   logic              we_p2;
   logic              is_load_p2;
   logic [ADDR_W-1:0] dst_p2;
   logic [ADDR_W-1:0] rs_a_p2;
   logic [ADDR_W-1:0] rs_b_p2;
   logic [DATA_W-1:0] alu_result_p3;
   logic [DATA_W-1:0] mem_rdata_p4;

   // Outputs of the pipeline
   logic [ADDR_W-1:0] write_addr_p3;
   logic [ADDR_W-1:0] write_addr_p4;
   logic [ADDR_W-1:0] write_addr_p5;
   logic [DATA_W-1:0] data_p3;
   logic [DATA_W-1:0] data_p4;
   logic [DATA_W-1:0] data_p5;
   logic              write_p3;
   logic              write_p4;
   logic              write_p5;
   logic              load_use_hazard;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [CNT_W-1:0]  retired_count;

   modport master (
      input  hold, flush_p3, valid_p2, we_p2, is_load_p2,
             dst_p2, rs_a_p2, rs_b_p2, alu_result_p3, mem_rdata_p4,
      output write_addr_p3, write_addr_p4, write_addr_p5,
             data_p3, data_p4, data_p5,
             write_p3, write_p4, write_p5,
             load_use_hazard, rf_we, rf_waddr, rf_wdata, retired_count
   );

   modport slave (
      output hold, flush_p3, valid_p2, we_p2, is_load_p2,
             dst_p2, rs_a_p2, rs_b_p2, alu_result_p3, mem_rdata_p4,
      input  write_addr_p3, write_addr_p4, write_addr_p5,
             data_p3, data_p4, data_p5,
             write_p3, write_p4, write_p5,
             load_use_hazard, rf_we, rf_waddr, rf_wdata, retired_count
   );

endinterface

// File: rtl/result_pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// result_pipeline_stage_reg
// One pipeline stage: destination metadata plus (optionally) a result register.
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high; empties the stage
//   hold     : keep every register of the stage
//   bubble   : load an empty slot instead of meta_in (data is left alone)
//   meta_in  : metadata from the previous stage
//   data_in  : result captured together with meta_in (HAS_DATA only)
//   meta_out : registered metadata
//   data_out : registered result (zero when HAS_DATA = 0)
// -----------------------------------------------------------------------------
module result_pipeline_stage_reg
   import result_pipeline_pkg::*;
#(
   parameter bit HAS_DATA = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              hold,
   input  logic              bubble,
   input  stage_meta_t       meta_in,
   input  logic [DATA_W-1:0] data_in,
   output stage_meta_t       meta_out,
   output logic [DATA_W-1:0] data_out
);

   stage_meta_t meta_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_reg <= STAGE_BUBBLE;
      end else if (!hold) begin
         if (bubble) begin
            meta_reg <= STAGE_BUBBLE;
         end else begin
            meta_reg <= meta_in;
         end
      end
   end

   assign meta_out = meta_reg;

   generate
      if (HAS_DATA) begin : g_data
         logic [DATA_W-1:0] data_reg;

         // Data follows the slot even when the slot is empty; consumers
         // qualify it with the metadata.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               data_reg <= '0;
            end else if (!hold && !bubble) begin
               data_reg <= data_in;
            end
         end

         assign data_out = data_reg;
      end else begin : g_no_data
         // The EX stage result is the live ALU output, so nothing is stored.
         logic unused_data;
         assign unused_data = ^data_in;
         assign data_out    = '0;
      end
   endgenerate

endmodule

// File: rtl/result_pipeline.sv
// -----------------------------------------------------------------------------
// result_pipeline
// Producer side of operand forwarding. Carries destination metadata and
// results of in-flight instructions through p3 (EX), p4 (MEM) and p5 (WB),
// drives the per-stage forwarding taps, the register-file write port, the
// load-use hazard flag and a retired-instruction counter.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; discards all in-flight instructions
//   bus   : result_pipeline_if.master (decode inputs, ALU/memory data in,
//           forwarding taps, hazard, register-file port, retired_count out)
// -----------------------------------------------------------------------------
module result_pipeline
   import result_pipeline_pkg::*;
(
   input logic               clock,
   input logic               reset,
   result_pipeline_if.master bus
);

   stage_meta_t             meta_d [NUM_STAGES];
   stage_meta_t             meta_q [NUM_STAGES];
   logic [DATA_W-1:0]       data_d [NUM_STAGES];
   logic [DATA_W-1:0]       data_q [NUM_STAGES];
   logic [NUM_STAGES-1:0]   bubble_vec;
   logic [DATA_W-1:0]       data_p4_tap;
   logic                    load_use_hazard;
   logic [CNT_W-1:0]        retired_count_reg;

   // -------------------------------------------------------------------------
   // Load-use hazard: the load in p3 has no data until p4, so a p2 consumer
   // of its destination must wait one cycle. Deliberately not gated by hold;
   // the stall logic upstream decides what to do with it.
   // -------------------------------------------------------------------------
   assign load_use_hazard = bus.valid_p2
                          & meta_q[S_P3].valid
                          & meta_q[S_P3].we
                          & meta_q[S_P3].is_load
                          & ((bus.rs_a_p2 == meta_q[S_P3].dst) |
                             (bus.rs_b_p2 == meta_q[S_P3].dst));

   // Only p3 ever takes a bubble; later stages always drain forward. Once the
   // bubble is in p3 the hazard clears, so a load costs exactly one cycle.
   assign bubble_vec[S_P3] = bus.flush_p3 | load_use_hazard | ~bus.valid_p2;
   assign bubble_vec[S_P4] = 1'b0;
   assign bubble_vec[S_P5] = 1'b0;

   // Stage inputs: p2 fields feed p3, each stage feeds the next.
   assign meta_d[S_P3] = {bus.valid_p2, bus.we_p2, bus.is_load_p2, bus.dst_p2};
   assign meta_d[S_P4] = meta_q[S_P3];
   assign meta_d[S_P5] = meta_q[S_P4];

   assign data_d[S_P3] = '0;
   assign data_d[S_P4] = bus.alu_result_p3;
   // A load's data arrives during p4, so p5 captures the merged p4 tap.
   assign data_d[S_P5] = data_p4_tap;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         result_pipeline_stage_reg #(
            .HAS_DATA (gi != S_P3)
         ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .hold     (bus.hold),
            .bubble   (bubble_vec[gi]),
            .meta_in  (meta_d[gi]),
            .data_in  (data_d[gi]),
            .meta_out (meta_q[gi]),
            .data_out (data_q[gi])
         );
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Forwarding taps
   // -------------------------------------------------------------------------
   assign data_p4_tap = meta_q[S_P4].is_load ? bus.mem_rdata_p4 : data_q[S_P4];

   // A load in p3 cannot forward: its value does not exist yet.
   assign bus.write_p3      = meta_writes(meta_q[S_P3]) & ~meta_q[S_P3].is_load;
   assign bus.write_addr_p3 = meta_q[S_P3].dst;
   assign bus.data_p3       = bus.alu_result_p3;

   assign bus.write_p4      = meta_writes(meta_q[S_P4]);
   assign bus.write_addr_p4 = meta_q[S_P4].dst;
   assign bus.data_p4       = data_p4_tap;

   assign bus.write_p5      = meta_writes(meta_q[S_P5]);
   assign bus.write_addr_p5 = meta_q[S_P5].dst;
   assign bus.data_p5       = data_q[S_P5];

   assign bus.load_use_hazard = load_use_hazard;

   // Register-file port mirrors the WB tap; a repeated write while held
   // rewrites the same value and is harmless.
   assign bus.rf_we    = meta_writes(meta_q[S_P5]);
   assign bus.rf_waddr = meta_q[S_P5].dst;
   assign bus.rf_wdata = data_q[S_P5];

   // -------------------------------------------------------------------------
   // Retire counter: counts every real instruction leaving p5, including
   // ones that do not write a register. Wraps naturally.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         retired_count_reg <= '0;
      end else if (!bus.hold && meta_q[S_P5].valid) begin
         retired_count_reg <= retired_count_reg + CNT_W'(1);
      end
   end

   assign bus.retired_count = retired_count_reg;

endmodule

// File: tb/tb_result_pipeline.sv
// -----------------------------------------------------------------------------
// tb_result_pipeline
// Directed bench for result_pipeline. A record-level model of the three
// in-flight instructions predicts every output; one compare process checks
// all outputs against it on each falling edge and also applies hand-computed
// literal expectations queued by the stimulus.
// -----------------------------------------------------------------------------
module tb_result_pipeline;
   import result_pipeline_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   result_pipeline_if bus_if ();

   result_pipeline dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus_if)
   );

   // ---------------------------------------------------------------- model
   typedef struct {
      bit        v;
      bit        we;
      bit        ld;
      bit [2:0]  dst;
      bit [15:0] data;
   } instr_t;

   instr_t    m_p3, m_p4, m_p5;
   bit [15:0] m_retired;

   typedef enum int {
      O_WP3, O_AP3, O_DP3, O_WP4, O_AP4, O_DP4, O_WP5, O_AP5, O_DP5,
      O_HAZ, O_RFWE, O_RFWA, O_RFWD, O_RET
   } out_sel_t;

   typedef struct {
      string       name;
      out_sel_t    sel;
      logic [31:0] val;
   } pin_t;

   pin_t pins[$];
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   function automatic instr_t empty_instr();
      instr_t e;
      e = '{default: '0};
      return e;
   endfunction

   function automatic bit model_hazard();
      return bus_if.valid_p2 && m_p3.v && m_p3.we && m_p3.ld &&
             ((bus_if.rs_a_p2 == m_p3.dst) || (bus_if.rs_b_p2 == m_p3.dst));
   endfunction

   function automatic logic [31:0] model_out(input out_sel_t s);
      case (s)
         O_WP3:   return 32'(m_p3.v && m_p3.we && !m_p3.ld);
         O_AP3:   return 32'(m_p3.dst);
         O_DP3:   return 32'(bus_if.alu_result_p3);
         O_WP4:   return 32'(m_p4.v && m_p4.we);
         O_AP4:   return 32'(m_p4.dst);
         O_DP4:   return 32'(m_p4.ld ? bus_if.mem_rdata_p4 : m_p4.data);
         O_WP5:   return 32'(m_p5.v && m_p5.we);
         O_AP5:   return 32'(m_p5.dst);
         O_DP5:   return 32'(m_p5.data);
         O_HAZ:   return 32'(model_hazard());
         O_RFWE:  return 32'(m_p5.v && m_p5.we);
         O_RFWA:  return 32'(m_p5.dst);
         O_RFWD:  return 32'(m_p5.data);
         O_RET:   return 32'(m_retired);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic logic [31:0] dut_out(input out_sel_t s);
      case (s)
         O_WP3:   return 32'(bus_if.write_p3);
         O_AP3:   return 32'(bus_if.write_addr_p3);
         O_DP3:   return 32'(bus_if.data_p3);
         O_WP4:   return 32'(bus_if.write_p4);
         O_AP4:   return 32'(bus_if.write_addr_p4);
         O_DP4:   return 32'(bus_if.data_p4);
         O_WP5:   return 32'(bus_if.write_p5);
         O_AP5:   return 32'(bus_if.write_addr_p5);
         O_DP5:   return 32'(bus_if.data_p5);
         O_HAZ:   return 32'(bus_if.load_use_hazard);
         O_RFWE:  return 32'(bus_if.rf_we);
         O_RFWA:  return 32'(bus_if.rf_waddr);
         O_RFWD:  return 32'(bus_if.rf_wdata);
         O_RET:   return 32'(bus_if.retired_count);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // One clock edge of the pipeline at instruction level.
   task automatic model_edge();
      bit bub;
      if (rst || bus_if.hold) return;
      bub = bus_if.flush_p3 || model_hazard() || !bus_if.valid_p2;
      if (m_p5.v) m_retired = m_retired + 16'd1;
      m_p5 = m_p4;
      if (m_p4.ld) m_p5.data = bus_if.mem_rdata_p4;
      m_p4 = m_p3;
      m_p4.data = bus_if.alu_result_p3;
      if (bub) begin
         m_p3 = empty_instr();
      end else begin
         m_p3 = '{v: 1'b1, we: bus_if.we_p2, ld: bus_if.is_load_p2,
                  dst: bus_if.dst_p2, data: 16'h0000};
      end
   endtask

   task automatic model_reset();
      m_p3 = empty_instr();
      m_p4 = empty_instr();
      m_p5 = empty_instr();
      m_retired = 16'h0000;
   endtask

   // --------------------------------------------------------- compare side
   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", name, actual, required, $time);
      end
   endtask

   int pin_rd = 0;

   always @(negedge clk) begin
      out_sel_t sel;
      for (int s = 0; s <= int'(O_RET); s++) begin
         sel = out_sel_t'(s);
         check({"model_", sel.name()}, dut_out(sel), model_out(sel));
      end
      while (pin_rd < pins.size()) begin
         check(pins[pin_rd].name, dut_out(pins[pin_rd].sel), pins[pin_rd].val);
         pin_rd++;
      end
   end

   // -------------------------------------------------------- stimulus side
   task automatic pin(input string name, input out_sel_t sel, input logic [31:0] val);
      pin_t p;
      p.name = name;
      p.sel  = sel;
      p.val  = val;
      pins.push_back(p);
   endtask

   task automatic drive(input bit v, input bit we, input bit ld,
                        input logic [2:0] dst, input logic [2:0] rsa, input logic [2:0] rsb,
                        input logic [15:0] alu, input logic [15:0] mem,
                        input bit hold, input bit flush);
      bus_if.valid_p2      = v;
      bus_if.we_p2         = we;
      bus_if.is_load_p2    = ld;
      bus_if.dst_p2        = dst;
      bus_if.rs_a_p2       = rsa;
      bus_if.rs_b_p2       = rsb;
      bus_if.alu_result_p3 = alu;
      bus_if.mem_rdata_p4  = mem;
      bus_if.hold          = hold;
      bus_if.flush_p3      = flush;
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      step_no++;
      $display("step %0d: p3 v=%0b dst=%0d | p4 v=%0b dst=%0d | p5 v=%0b dst=%0d data=%h | retired=%h",
               step_no, m_p3.v, m_p3.dst, m_p4.v, m_p4.dst, m_p5.v, m_p5.dst, m_p5.data, m_retired);
   endtask

   initial begin
      rst = 1'b1;
      nop();
      model_reset();
      #1;
      pin("reset_write_p3", O_WP3, 32'd0);
      pin("reset_write_p5", O_WP5, 32'd0);
      pin("reset_rf_we",    O_RFWE, 32'd0);
      pin("reset_hazard",   O_HAZ, 32'd0);
      pin("reset_retired",  O_RET, 32'd0);
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;

      // ALU chain: ADD r1, then ADD r2 <- r1
      drive(1, 1, 0, 3'd1, 3'd0, 3'd0, 16'h0000, 16'h0000, 0, 0);
      tick();
      drive(1, 1, 0, 3'd2, 3'd1, 3'd0, 16'h1234, 16'h0000, 0, 0);
      pin("alu_write_p3", O_WP3, 32'd1);
      pin("alu_addr_p3",  O_AP3, 32'd1);
      pin("alu_data_p3",  O_DP3, 32'h1234);
      tick();
      drive(0, 0, 0, 3'd0, 3'd0, 3'd0, 16'h5678, 16'h0000, 0, 0);
      pin("alu_write_p4", O_WP4, 32'd1);
      pin("alu_addr_p4",  O_AP4, 32'd1);
      pin("alu_data_p4",  O_DP4, 32'h1234);
      tick();

      // Load-use: LD r3, then ADD r4 <- r3
      drive(1, 1, 1, 3'd3, 3'd0, 3'd0, 16'h0000, 16'h0000, 0, 0);
      pin("alu_rf_we",    O_RFWE, 32'd1);
      pin("alu_rf_waddr", O_RFWA, 32'd1);
      pin("alu_rf_wdata", O_RFWD, 32'h1234);
      tick();
      drive(1, 1, 0, 3'd4, 3'd3, 3'd0, 16'h0000, 16'h0000, 0, 0);
      pin("lu_hazard_on",  O_HAZ, 32'd1);
      pin("lu_write_p3",   O_WP3, 32'd0);
      pin("lu_addr_p3",    O_AP3, 32'd3);
      pin("lu_retired",    O_RET, 32'd1);
      tick();
      drive(1, 1, 0, 3'd4, 3'd3, 3'd0, 16'h0000, 16'hBEEF, 0, 0);
      pin("lu_write_p4",   O_WP4, 32'd1);
      pin("lu_data_p4",    O_DP4, 32'hBEEF);
      pin("lu_hazard_off", O_HAZ, 32'd0);
      pin("lu_bubble_p3",  O_WP3, 32'd0);
      tick();
      drive(1, 1, 0, 3'd5, 3'd0, 3'd0, 16'h0044, 16'h0000, 0, 0);
      pin("lu_one_bubble", O_WP3, 32'd1);
      pin("lu_addr_p3_r4", O_AP3, 32'd4);
      pin("lu_rf_waddr",   O_RFWA, 32'd3);
      pin("lu_rf_wdata",   O_RFWD, 32'hBEEF);
      pin("lu_retired2",   O_RET, 32'd2);
      tick();

      // Hold with p3/p4/p5 all valid
      drive(1, 1, 0, 3'd6, 3'd0, 3'd0, 16'h0055, 16'h0000, 0, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 0, 3'd7, 3'd0, 3'd0, 16'h0066, 16'h0000, (k < 3), 0);
         pin("hold_addr_p3",  O_AP3, 32'd6);
         pin("hold_data_p4",  O_DP4, 32'h0055);
         pin("hold_addr_p4",  O_AP4, 32'd5);
         pin("hold_rf_waddr", O_RFWA, 32'd4);
         pin("hold_rf_wdata", O_RFWD, 32'h0044);
         pin("hold_retired",  O_RET, 32'd3);
         tick();
      end

      // Flush with a valid p2 instruction
      drive(1, 1, 0, 3'd2, 3'd0, 3'd0, 16'h0077, 16'h0000, 0, 1);
      pin("resume_addr_p5", O_AP5, 32'd5);
      pin("resume_data_p5", O_DP5, 32'h0055);
      pin("resume_data_p4", O_DP4, 32'h0066);
      pin("resume_addr_p3", O_AP3, 32'd7);
      pin("resume_retired", O_RET, 32'd4);
      tick();
      drive(1, 1, 0, 3'd1, 3'd0, 3'd0, 16'h0011, 16'h0000, 0, 0);
      pin("flush_write_p3", O_WP3, 32'd0);
      pin("flush_addr_p4",  O_AP4, 32'd7);
      pin("flush_data_p4",  O_DP4, 32'h0077);
      pin("flush_addr_p5",  O_AP5, 32'd6);
      pin("flush_retired",  O_RET, 32'd5);
      tick();

      // Asynchronous reset between edges with r1 in p3 and r7 in p5
      nop();
      #2;
      rst = 1'b1;
      model_reset();
      pin("areset_write_p3", O_WP3, 32'd0);
      pin("areset_write_p5", O_WP5, 32'd0);
      pin("areset_rf_we",    O_RFWE, 32'd0);
      pin("areset_retired",  O_RET, 32'd0);
      tick();
      @(negedge clk);
      rst = 1'b0;

      // Counter wrap: fill the pipe, preload near the top, drain
      drive(1, 1, 0, 3'd1, 3'd0, 3'd0, 16'h0000, 16'h0000, 0, 0);
      tick();
      drive(1, 1, 0, 3'd2, 3'd0, 3'd0, 16'h0101, 16'h0000, 0, 0);
      tick();
      drive(1, 1, 0, 3'd3, 3'd0, 3'd0, 16'h0202, 16'h0000, 0, 0);
      tick();
      drive(0, 0, 0, 3'd0, 3'd0, 3'd0, 16'h0303, 16'h0000, 1, 0);
      force dut.retired_count_reg = 16'hFFFE;
      #1;
      release dut.retired_count_reg;
      m_retired = 16'hFFFE;
      pin("wrap_preload", O_RET, 32'hFFFE);
      tick();
      drive(0, 0, 0, 3'd0, 3'd0, 3'd0, 16'h0303, 16'h0000, 0, 0);
      pin("wrap_hold_kept", O_RET, 32'hFFFE);
      tick();
      pin("wrap_ffff", O_RET, 32'hFFFF);
      tick();
      pin("wrap_zero", O_RET, 32'h0000);
      pin("wrap_rf_wdata", O_RFWD, 32'h0303);
      tick();
      pin("wrap_one", O_RET, 32'h0001);

      // Hazard via rs_b, then near-misses that must not stall
      drive(1, 1, 1, 3'd2, 3'd0, 3'd0, 16'h0000, 16'h0000, 0, 0);
      tick();
      drive(1, 0, 0, 3'd0, 3'd5, 3'd2, 16'h0000, 16'h0000, 0, 0);
      pin("rsb_hazard_on", O_HAZ, 32'd1);
      tick();
      drive(1, 1, 1, 3'd6, 3'd5, 3'd2, 16'h0000, 16'h00AA, 0, 0);
      pin("rsb_hazard_off", O_HAZ, 32'd0);
      tick();
      drive(1, 1, 0, 3'd1, 3'd5, 3'd4, 16'h0000, 16'h0000, 0, 0);
      pin("nomatch_hazard", O_HAZ, 32'd0);
      pin("ld_write_p3",    O_WP3, 32'd0);
      tick();
      drive(1, 1, 1, 3'd6, 3'd0, 3'd0, 16'h0000, 16'h0000, 0, 0);
      tick();
      drive(0, 0, 0, 3'd0, 3'd6, 3'd6, 16'h0000, 16'h0000, 0, 0);
      pin("invalid_p2_hazard", O_HAZ, 32'd0);
      tick();

      nop();
      tick();
      tick();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
